mode_switch_ctrl: RTL and testbench
===================================

Name: mode_switch_ctrl

Overview:
- Generalised run-mode controller for the board top level.
- Takes debounced per-mode key pulses and selects one of NUM_MODES modes; mode 0 is idle.
- Generates per-mode enables and a stretched reset for the shared SDRAM controller.
- Owns the registered mux that gives the current mode's client the single SDRAM burst port, and drains in-flight bursts safely before any hand-over.

Parameters:
- NUM_MODES, 4, number of modes including idle mode 0 (2..16).
- ADDR_W, 24, burst address width.
- LEN_W, 10, burst length width.
- DATA_W, 16, write data width.
- RST_STRETCH, 16, cycles shared_rst_n is held low per reset (>=2).
- DRAIN_TIMEOUT, 1024, drain watchdog limit in cycles (feature only).
- Localparam MODE_W = $clog2(NUM_MODES).

Ports:
- clk  in  1  system clock; every port is synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- key_press  in  NUM_MODES  one-cycle debounced request pulses; bit m requests mode m.
- mem_busy  in  1  shared SDRAM controller has a burst in progress.
- cli_rd_req  in  NUM_MODES  per-client read burst request.
- cli_wr_req  in  NUM_MODES  per-client write burst request.
- cli_rd_len / cli_wr_len  in  NUM_MODES*LEN_W  packed per-client burst lengths.
- cli_rd_addr / cli_wr_addr  in  NUM_MODES*ADDR_W  packed per-client burst addresses.
- cli_wr_data  in  NUM_MODES*DATA_W  packed per-client write data.
- rd_burst_req, wr_burst_req  out  1  muxed requests to the SDRAM controller.
- rd_burst_len, wr_burst_len  out  LEN_W  muxed lengths.
- rd_burst_addr, wr_burst_addr  out  ADDR_W  muxed addresses.
- wr_burst_data  out  DATA_W  muxed write data.
- cur_mode  out  MODE_W  active mode index.
- mode_rst_n  out  NUM_MODES  per-mode active-low reset; bit m is high only while in RUN with cur_mode==m.
- shared_rst_n  out  1  shared SDRAM controller reset.
- switching  out  1  high in DRAIN or RESET.
- mode_change  out  1  one-cycle pulse on entry to RUN.
- timeout_err  out  1  one-cycle pulse on drain timeout (feature only; otherwise tied 0).

Behaviour:
- Reset values:
  - state=RESET, cur_mode=0, target=0, stretch count=0.
  - All mode_rst_n=0, shared_rst_n=0, switching=1.
  - All burst outputs=0; mode_change=0, timeout_err=0.
- FSM states: RUN, DRAIN, RESET.
- Key arbitration: among bits set in key_press in one cycle, the lowest index wins.
- RUN:
  - A winning request with index != cur_mode latches target and moves to DRAIN next cycle.
  - A request equal to cur_mode is ignored.
  - Burst port is driven from client cur_mode.
- DRAIN:
  - rd/wr_burst_req are forced 0; len, addr and data hold their last values.
  - mode_rst_n is all 0 from the first DRAIN cycle.
  - Exits to RESET in the first cycle mem_busy==0; this takes one cycle if idle.
- RESET:
  - shared_rst_n=0 for exactly RST_STRETCH cycles, then go to RUN.
  - cur_mode<=target on RUN entry, mode_change pulses, shared_rst_n=1.
  - mode_rst_n[cur_mode]=1 in the first RUN cycle.
- Key press during DRAIN/RESET:
  - The winner overwrites target, including when it equals the old mode; landing on the old mode acts as a restart.
  - The stretch count is not restarted.
- Burst mux:
  - Registered, 1-cycle latency from cli_* to burst outputs.
  - In mode 0 all requests are 0; client 0 inputs are ignored.
  - Non-owner clients are never visible at the outputs.
- Post-reset: on rst_n release, RESET runs RST_STRETCH cycles, then RUN in mode 0 with mode_change pulsed.
- Asynchronous rst_n mid-operation: immediate return to reset values, whatever the state or in-flight burst.
- A key_press index >= NUM_MODES cannot occur by width.

Optional Feature:
- Macro: MODE_SWITCH_TIMEOUT_EN.
- Defined: a DRAIN counter counts cycles with mem_busy==1. At DRAIN_TIMEOUT, go to RESET regardless of mem_busy and pulse timeout_err. The counter clears on DRAIN entry.
- Undefined: DRAIN waits indefinitely for mem_busy==0; timeout_err is constant 0 and no counter is built.

Decomposition:
- Package mode_switch_pkg holds:
  - state enum typedef (RUN, DRAIN, RESET);
  - mode index constant MODE_IDLE=0;
  - function lowest_set_index for arbitration.
- One sub-module, burst_port_mux: parametrised, registered N:1 burst bus mux with a force-idle input.
- The FSM and counters stay in mode_switch_ctrl.

Test Plan:
- Reset release, RST_STRETCH=16 -> shared_rst_n low 16 cycles then high; cur_mode=0; mode_rst_n=4'b0000; one mode_change pulse.
- In mode 0, key_press=4'b0100 with mem_busy=0 -> 1 cycle DRAIN, 16 cycles RESET; then cur_mode=2, mode_rst_n=4'b0100, switching=0.
- key_press=4'b1010 in mode 0 -> target=1; mode 1 entered; mode 3 never enabled.
- Mode 3, client 3 rd_req=1, len=256, addr=24'h012345 -> outputs match one cycle later. key_press=4'b0010 with mem_busy high 40 cycles -> rd_burst_req=0 throughout DRAIN; RESET starts after busy falls.
- Mode 1, key 2 then key 3 during RESET -> final cur_mode=3 with a single RESET period (no count restart).
- MODE_SWITCH_TIMEOUT_EN with DRAIN_TIMEOUT=64 and mem_busy stuck high -> timeout_err pulse after 64 DRAIN cycles, then normal RESET. Without the macro -> remains in DRAIN and timeout_err=0.

Source files
------------

// File: rtl/mode_switch_ctrl_pkg.sv
// Shared types and helpers for the run-mode controller: FSM state encoding,
// the idle mode index and the key arbitration function.
package mode_switch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RESET = 2'd2
  } state_e;

  localparam int MODE_IDLE = 0;

  // Lowest set bit wins; returns 0 for an empty vector, so callers test for any bit set first.
  function automatic logic [3:0] lowest_set_index(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mode_switch_ctrl_if.sv
// Single SDRAM burst port between the run-mode controller (master) and the
// shared SDRAM controller (slave).
interface mode_switch_ctrl_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 16
);

  logic              rd_burst_req;
  logic              wr_burst_req;
  logic [LEN_W-1:0]  rd_burst_len;
  logic [LEN_W-1:0]  wr_burst_len;
  logic [ADDR_W-1:0] rd_burst_addr;
  logic [ADDR_W-1:0] wr_burst_addr;
  logic [DATA_W-1:0] wr_burst_data;
  logic              mem_busy;

  modport master (
    output rd_burst_req, wr_burst_req,
    output rd_burst_len, wr_burst_len,
    output rd_burst_addr, wr_burst_addr,
    output wr_burst_data,
    input  mem_busy
  );

  modport slave (
    input  rd_burst_req, wr_burst_req,
    input  rd_burst_len, wr_burst_len,
    input  rd_burst_addr, wr_burst_addr,
    input  wr_burst_data,
    output mem_busy
  );

endinterface

// File: rtl/mode_switch_ctrl_burst_port_mux.sv
// Registered N:1 burst bus mux. While force-idle is high the requests drop to 0
// and the length/address/data registers keep their last values.
module burst_port_mux #(
  parameter int N      = 4,
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 16,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_force_idle,
  input  logic [N-1:0]        i_rd_req,
  input  logic [N-1:0]        i_wr_req,
  input  logic [N*LEN_W-1:0]  i_rd_len,
  input  logic [N*LEN_W-1:0]  i_wr_len,
  input  logic [N*ADDR_W-1:0] i_rd_addr,
  input  logic [N*ADDR_W-1:0] i_wr_addr,
  input  logic [N*DATA_W-1:0] i_wr_data,
  output logic                o_rd_req,
  output logic                o_wr_req,
  output logic [LEN_W-1:0]    o_rd_len,
  output logic [LEN_W-1:0]    o_wr_len,
  output logic [ADDR_W-1:0]   o_rd_addr,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data
);

  logic [LEN_W-1:0]  w_rd_len  [N];
  logic [LEN_W-1:0]  w_wr_len  [N];
  logic [ADDR_W-1:0] w_rd_addr [N];
  logic [ADDR_W-1:0] w_wr_addr [N];
  logic [DATA_W-1:0] w_wr_data [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_rd_len[gi]  = i_rd_len[gi*LEN_W +: LEN_W];
    assign w_wr_len[gi]  = i_wr_len[gi*LEN_W +: LEN_W];
    assign w_rd_addr[gi] = i_rd_addr[gi*ADDR_W +: ADDR_W];
    assign w_wr_addr[gi] = i_wr_addr[gi*ADDR_W +: ADDR_W];
    assign w_wr_data[gi] = i_wr_data[gi*DATA_W +: DATA_W];
  end

  logic              r_rd_req;
  logic              r_wr_req;
  logic [LEN_W-1:0]  r_rd_len;
  logic [LEN_W-1:0]  r_wr_len;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_req  <= 1'b0;
      r_wr_req  <= 1'b0;
      r_rd_len  <= '0;
      r_wr_len  <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (i_force_idle) begin
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
    end else begin
      r_rd_req  <= i_rd_req[i_sel];
      r_wr_req  <= i_wr_req[i_sel];
      r_rd_len  <= w_rd_len[i_sel];
      r_wr_len  <= w_wr_len[i_sel];
      r_rd_addr <= w_rd_addr[i_sel];
      r_wr_addr <= w_wr_addr[i_sel];
      r_wr_data <= w_wr_data[i_sel];
    end
  end

  assign o_rd_req  = r_rd_req;
  assign o_wr_req  = r_wr_req;
  assign o_rd_len  = r_rd_len;
  assign o_wr_len  = r_wr_len;
  assign o_rd_addr = r_rd_addr;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

endmodule

// File: rtl/mode_switch_ctrl.sv
// Run-mode controller: key arbitration, drain/reset sequencing, per-mode enables
// and SDRAM port ownership. Define MODE_SWITCH_TIMEOUT_EN for the drain watchdog.
module mode_switch_ctrl
  import mode_switch_pkg::*;
#(
  parameter int NUM_MODES     = 4,
  parameter int ADDR_W        = 24,
  parameter int LEN_W         = 10,
  parameter int DATA_W        = 16,
  parameter int RST_STRETCH   = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  localparam int MODE_W       = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MODES-1:0]        i_key_press,
  input  logic [NUM_MODES-1:0]        i_cli_rd_req,
  input  logic [NUM_MODES-1:0]        i_cli_wr_req,
  input  logic [NUM_MODES*LEN_W-1:0]  i_cli_rd_len,
  input  logic [NUM_MODES*LEN_W-1:0]  i_cli_wr_len,
  input  logic [NUM_MODES*ADDR_W-1:0] i_cli_rd_addr,
  input  logic [NUM_MODES*ADDR_W-1:0] i_cli_wr_addr,
  input  logic [NUM_MODES*DATA_W-1:0] i_cli_wr_data,
  mode_switch_ctrl_if.master          mem_if,
  output logic [MODE_W-1:0]           o_cur_mode,
  output logic [NUM_MODES-1:0]        o_mode_rst_n,
  output logic                        o_shared_rst_n,
  output logic                        o_switching,
  output logic                        o_mode_change,
  output logic                        o_timeout_err
);

  localparam int STRETCH_W = $clog2(RST_STRETCH);

  if (NUM_MODES < 2 || NUM_MODES > 16 || RST_STRETCH < 2 || DRAIN_TIMEOUT < 2) begin : g_param_check
    $error("mode_switch_ctrl: parameter out of range");
  end

  state_e                r_state;
  state_e                w_state_next;
  logic [MODE_W-1:0]     r_cur_mode;
  logic [MODE_W-1:0]     w_cur_mode_next;
  logic [MODE_W-1:0]     r_target;
  logic [MODE_W-1:0]     w_target_next;
  logic [STRETCH_W-1:0]  r_stretch_cnt;
  logic [STRETCH_W-1:0]  w_stretch_next;
  logic                  r_mode_change;
  logic                  w_mode_change_next;
  logic                  w_key_hit;
  logic [MODE_W-1:0]     w_key_idx;
  logic                  w_mux_idle;

`ifdef MODE_SWITCH_TIMEOUT_EN
  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT);
  logic [DRAIN_W-1:0]    r_drain_cnt;
  logic [DRAIN_W-1:0]    w_drain_next;
  logic                  r_timeout_err;
  logic                  w_timeout_next;
`endif

  assign w_key_hit = |i_key_press;
  assign w_key_idx = MODE_W'(lowest_set_index(16'(i_key_press)));

  always_comb begin
    w_state_next       = r_state;
    w_cur_mode_next    = r_cur_mode;
    w_target_next      = r_target;
    w_stretch_next     = r_stretch_cnt;
    w_mode_change_next = 1'b0;
`ifdef MODE_SWITCH_TIMEOUT_EN
    w_drain_next       = r_drain_cnt;
    w_timeout_next     = 1'b0;
`endif
    case (r_state)
      ST_RUN: begin
        if (w_key_hit && (w_key_idx != r_cur_mode)) begin
          w_target_next = w_key_idx;
          w_state_next  = ST_DRAIN;
`ifdef MODE_SWITCH_TIMEOUT_EN
          w_drain_next  = '0;
`endif
        end
      end
      ST_DRAIN: begin
        if (w_key_hit) w_target_next = w_key_idx;
        if (!mem_if.mem_busy) begin
          w_state_next = ST_RESET;
        end
`ifdef MODE_SWITCH_TIMEOUT_EN
        else if (r_drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
          w_state_next   = ST_RESET;
          w_timeout_next = 1'b1;
        end else begin
          w_drain_next = r_drain_cnt + 1'b1;
        end
`endif
      end
      ST_RESET: begin
        // Late keys only retarget; the stretch keeps counting from where it was.
        if (w_key_hit) w_target_next = w_key_idx;
        if (r_stretch_cnt == STRETCH_W'(RST_STRETCH - 1)) begin
          w_state_next       = ST_RUN;
          w_stretch_next     = '0;
          w_cur_mode_next    = w_target_next;
          w_mode_change_next = 1'b1;
        end else begin
          w_stretch_next = r_stretch_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next   = ST_RESET;
        w_stretch_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RESET;
      r_cur_mode    <= MODE_W'(MODE_IDLE);
      r_target      <= MODE_W'(MODE_IDLE);
      r_stretch_cnt <= '0;
      r_mode_change <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cur_mode    <= w_cur_mode_next;
      r_target      <= w_target_next;
      r_stretch_cnt <= w_stretch_next;
      r_mode_change <= w_mode_change_next;
    end
  end

`ifdef MODE_SWITCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_drain_cnt   <= w_drain_next;
      r_timeout_err <= w_timeout_next;
    end
  end
  assign o_timeout_err = r_timeout_err;
`else
  assign o_timeout_err = 1'b0;
`endif

  // Idle mode has no client, so its enable bit is never raised.
  for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_mode_rst
    if (gi == MODE_IDLE) begin : g_idle
      assign o_mode_rst_n[gi] = 1'b0;
    end else begin : g_client
      assign o_mode_rst_n[gi] = (r_state == ST_RUN) && (r_cur_mode == MODE_W'(gi));
    end
  end

  assign o_cur_mode     = r_cur_mode;
  assign o_shared_rst_n = (r_state != ST_RESET);
  assign o_switching    = (r_state != ST_RUN);
  assign o_mode_change  = r_mode_change;

  // Steer the mux from next-state values so requests drop on the very edge that
  // leaves RUN, and the new owner appears on the edge that enters RUN.
  assign w_mux_idle = (w_state_next != ST_RUN) || (w_cur_mode_next == MODE_W'(MODE_IDLE));

  burst_port_mux #(
    .N      (NUM_MODES),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .DATA_W (DATA_W)
  ) u_burst_port_mux (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sel        (w_cur_mode_next),
    .i_force_idle (w_mux_idle),
    .i_rd_req     (i_cli_rd_req),
    .i_wr_req     (i_cli_wr_req),
    .i_rd_len     (i_cli_rd_len),
    .i_wr_len     (i_cli_wr_len),
    .i_rd_addr    (i_cli_rd_addr),
    .i_wr_addr    (i_cli_wr_addr),
    .i_wr_data    (i_cli_wr_data),
    .o_rd_req     (mem_if.rd_burst_req),
    .o_wr_req     (mem_if.wr_burst_req),
    .o_rd_len     (mem_if.rd_burst_len),
    .o_wr_len     (mem_if.wr_burst_len),
    .o_rd_addr    (mem_if.rd_burst_addr),
    .o_wr_addr    (mem_if.wr_burst_addr),
    .o_wr_data    (mem_if.wr_burst_data)
  );

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Scoreboard bench for mode_switch_ctrl: directed key/busy/client vectors push
// expected mode entries, bursts and timeout pulses; a negedge monitor pops and checks.
module tb_mode_switch_ctrl;

  localparam int NUM_MODES     = 4;
  localparam int ADDR_W        = 24;
  localparam int LEN_W         = 10;
  localparam int DATA_W        = 16;
  localparam int RST_STRETCH   = 16;
  localparam int DRAIN_TIMEOUT = 64;
  localparam int MODE_W        = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_MODES-1:0]        key_press = '0;
  logic [NUM_MODES-1:0]        cli_rd_req = '0;
  logic [NUM_MODES-1:0]        cli_wr_req = '0;
  logic [NUM_MODES*LEN_W-1:0]  cli_rd_len = '0;
  logic [NUM_MODES*LEN_W-1:0]  cli_wr_len = '0;
  logic [NUM_MODES*ADDR_W-1:0] cli_rd_addr = '0;
  logic [NUM_MODES*ADDR_W-1:0] cli_wr_addr = '0;
  logic [NUM_MODES*DATA_W-1:0] cli_wr_data = '0;
  logic [MODE_W-1:0]           cur_mode;
  logic [NUM_MODES-1:0]        mode_rst_n;
  logic                        shared_rst_n;
  logic                        switching;
  logic                        mode_change;
  logic                        timeout_err;

  mode_switch_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) mem();

  mode_switch_ctrl #(
    .NUM_MODES(NUM_MODES), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
    .RST_STRETCH(RST_STRETCH), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_key_press(key_press),
    .i_cli_rd_req(cli_rd_req), .i_cli_wr_req(cli_wr_req),
    .i_cli_rd_len(cli_rd_len), .i_cli_wr_len(cli_wr_len),
    .i_cli_rd_addr(cli_rd_addr), .i_cli_wr_addr(cli_wr_addr),
    .i_cli_wr_data(cli_wr_data), .mem_if(mem),
    .o_cur_mode(cur_mode), .o_mode_rst_n(mode_rst_n),
    .o_shared_rst_n(shared_rst_n), .o_switching(switching),
    .o_mode_change(mode_change), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mode;
    logic [3:0] mask;
  } mode_exp_t;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } burst_exp_t;

  mode_exp_t  q_mode[$];
  burst_exp_t q_rd[$];
  burst_exp_t q_wr[$];
  int         q_to[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [NUM_MODES-1:0] k);
    key_press = k;
    step();
    key_press = '0;
  endtask

  task automatic wait_change(input int limit, output int n);
    n = 0;
    while (!mode_change && n < limit) begin
      step();
      n++;
    end
    chk("mode_change_within_bound", 64'(mode_change), 64'd1);
  endtask

  // Monitor: every DUT-presented event is matched against the expectation queues.
  initial begin : monitor
    mode_exp_t  me;
    burst_exp_t be;
    int         low_run;
    low_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_run = 0;
      end else begin
        if (!shared_rst_n) begin
          low_run++;
        end else if (low_run != 0) begin
          chk("rst_stretch_len", 64'(low_run), 64'(RST_STRETCH));
          low_run = 0;
        end
        if (mode_change) begin
          chk("mode_change_expected", 64'(q_mode.size() > 0), 64'd1);
          if (q_mode.size() > 0) begin
            me = q_mode.pop_front();
            $display("mode entry: cur_mode=%0d mode_rst_n=%b (exp %0d %b)", cur_mode, mode_rst_n, me.mode, me.mask);
            chk("cur_mode", 64'(cur_mode), 64'(me.mode));
            chk("mode_rst_n", 64'(mode_rst_n), 64'(me.mask));
            chk("switching_in_run", 64'(switching), 64'd0);
          end
        end
        if (mem.rd_burst_req) begin
          chk("rd_burst_expected", 64'(q_rd.size() > 0), 64'd1);
          if (q_rd.size() > 0) begin
            be = q_rd.pop_front();
            $display("rd burst: len=%0d addr=%h", mem.rd_burst_len, mem.rd_burst_addr);
            chk("rd_burst_len", 64'(mem.rd_burst_len), 64'(be.len));
            chk("rd_burst_addr", 64'(mem.rd_burst_addr), 64'(be.addr));
          end
        end
        if (mem.wr_burst_req) begin
          chk("wr_burst_expected", 64'(q_wr.size() > 0), 64'd1);
          if (q_wr.size() > 0) begin
            be = q_wr.pop_front();
            $display("wr burst: len=%0d addr=%h data=%h", mem.wr_burst_len, mem.wr_burst_addr, mem.wr_burst_data);
            chk("wr_burst_len", 64'(mem.wr_burst_len), 64'(be.len));
            chk("wr_burst_addr", 64'(mem.wr_burst_addr), 64'(be.addr));
            chk("wr_burst_data", 64'(mem.wr_burst_data), 64'(be.data));
          end
        end
        if (timeout_err) begin
          chk("timeout_expected", 64'(q_to.size() > 0), 64'd1);
          if (q_to.size() > 0) begin
            void'(q_to.pop_front());
            $display("timeout pulse in state switching=%0d", switching);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    mem.mem_busy = 1'b0;
    repeat (3) step();

    chk("rst_cur_mode", 64'(cur_mode), 64'd0);
    chk("rst_mode_rst_n", 64'(mode_rst_n), 64'd0);
    chk("rst_shared_rst_n", 64'(shared_rst_n), 64'd0);
    chk("rst_switching", 64'(switching), 64'd1);
    chk("rst_rd_req", 64'(mem.rd_burst_req), 64'd0);
    chk("rst_wr_req", 64'(mem.wr_burst_req), 64'd0);
    chk("rst_mode_change", 64'(mode_change), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);

    // Reset release lands in idle mode 0.
    q_mode.push_back(mode_exp_t'{4'd0, 4'b0000});
    rst_n = 1'b1;
    wait_change(40, n);
    chk("post_reset_latency", 64'(n), 64'd16);

    // Idle drain: 1 DRAIN cycle plus 16 RESET cycles.
    q_mode.push_back(mode_exp_t'{4'd2, 4'b0100});
    press(4'b0100);
    wait_change(40, n);
    chk("switch_0_to_2_latency", 64'(n), 64'd17);

    // Back to idle; client 0 requests must never reach the port.
    q_mode.push_back(mode_exp_t'{4'd0, 4'b0000});
    press(4'b0001);
    wait_change(40, n);
    chk("switch_2_to_0_latency", 64'(n), 64'd17);
    cli_rd_req = 4'b0001;
    cli_wr_req = 4'b0001;
    repeat (4) step();
    chk("idle_rd_req_blocked", 64'(mem.rd_burst_req), 64'd0);
    cli_rd_req = '0;
    cli_wr_req = '0;

    // Simultaneous keys 1 and 3: lowest index wins.
    q_mode.push_back(mode_exp_t'{4'd1, 4'b0010});
    press(4'b1010);
    wait_change(40, n);
    chk("switch_0_to_1_latency", 64'(n), 64'd17);

    q_mode.push_back(mode_exp_t'{4'd3, 4'b1000});
    press(4'b1000);
    wait_change(40, n);
    chk("switch_1_to_3_latency", 64'(n), 64'd17);

    // Owner client 3 bursts while non-owners 1 and 2 also request.
    cli_rd_len[3*LEN_W +: LEN_W]    = 10'd256;
    cli_rd_addr[3*ADDR_W +: ADDR_W] = 24'h012345;
    cli_wr_len[3*LEN_W +: LEN_W]    = 10'd5;
    cli_wr_addr[3*ADDR_W +: ADDR_W] = 24'h0ABCDE;
    cli_wr_data[3*DATA_W +: DATA_W] = 16'hBEEF;
    cli_rd_len[1*LEN_W +: LEN_W]    = 10'd7;
    cli_rd_addr[1*ADDR_W +: ADDR_W] = 24'h111111;
    cli_wr_len[2*LEN_W +: LEN_W]    = 10'd9;
    cli_wr_addr[2*ADDR_W +: ADDR_W] = 24'h222222;
    cli_wr_data[2*DATA_W +: DATA_W] = 16'h1234;
    q_rd.push_back(burst_exp_t'{10'd256, 24'h012345, 16'h0000});
    q_wr.push_back(burst_exp_t'{10'd5, 24'h0ABCDE, 16'hBEEF});
    cli_rd_req = 4'b1010;
    cli_wr_req = 4'b1100;
    step();
    chk("rd_one_cycle_latency", 64'(mem.rd_burst_req), 64'd1);
    cli_rd_req = '0;
    cli_wr_req = '0;
    step();

    // Switch 3 -> 1 while the controller is busy for 40 cycles; client 3 keeps requesting.
    mem.mem_busy = 1'b1;
    cli_rd_req = 4'b1000;
    q_mode.push_back(mode_exp_t'{4'd1, 4'b0010});
    press(4'b0010);
    for (int i = 0; i < 40; i++) begin
      chk("drain_shared_rst_n", 64'(shared_rst_n), 64'd1);
      chk("drain_mode_rst_n", 64'(mode_rst_n), 64'd0);
      chk("drain_rd_req", 64'(mem.rd_burst_req), 64'd0);
      step();
    end
    mem.mem_busy = 1'b0;
    wait_change(40, n);
    chk("busy_release_latency", 64'(n), 64'd17);
    cli_rd_req = '0;

    // Mode 1: key 2, then key 3 during RESET -> single reset period, ends in mode 3.
    q_mode.push_back(mode_exp_t'{4'd3, 4'b1000});
    press(4'b0100);
    repeat (5) step();
    press(4'b1000);
    wait_change(40, n);
    chk("retarget_latency", 64'(n), 64'd11);

`ifdef MODE_SWITCH_TIMEOUT_EN
    q_mode.push_back(mode_exp_t'{4'd2, 4'b0100});
    q_to.push_back(1);
    mem.mem_busy = 1'b1;
    press(4'b0100);
    n = 0;
    while (!timeout_err && n < 200) begin
      step();
      n++;
    end
    chk("timeout_latency", 64'(n), 64'd64);
    wait_change(40, n);
    chk("after_timeout_reset_len", 64'(n), 64'd16);
    mem.mem_busy = 1'b0;
`else
    q_mode.push_back(mode_exp_t'{4'd2, 4'b0100});
    mem.mem_busy = 1'b1;
    press(4'b0100);
    repeat (200) step();
    chk("stuck_drain_switching", 64'(switching), 64'd1);
    chk("stuck_drain_shared_rst_n", 64'(shared_rst_n), 64'd1);
    chk("stuck_drain_cur_mode", 64'(cur_mode), 64'd3);
    chk("stuck_drain_timeout_err", 64'(timeout_err), 64'd0);
    mem.mem_busy = 1'b0;
    wait_change(40, n);
    chk("stuck_release_latency", 64'(n), 64'd17);
`endif

    // Asynchronous reset with client 2's burst on the port.
    cli_rd_len[2*LEN_W +: LEN_W]    = 10'd33;
    cli_rd_addr[2*ADDR_W +: ADDR_W] = 24'h0F0F0F;
    cli_rd_req = 4'b0100;
    step();
    chk("inflight_rd_req", 64'(mem.rd_burst_req), 64'd1);
    chk("inflight_rd_addr", 64'(mem.rd_burst_addr), 64'h0F0F0F);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_cur_mode", 64'(cur_mode), 64'd0);
    chk("async_mode_rst_n", 64'(mode_rst_n), 64'd0);
    chk("async_shared_rst_n", 64'(shared_rst_n), 64'd0);
    chk("async_switching", 64'(switching), 64'd1);
    chk("async_rd_req", 64'(mem.rd_burst_req), 64'd0);
    chk("async_rd_addr", 64'(mem.rd_burst_addr), 64'd0);
    cli_rd_req = '0;
    step();
    q_mode.push_back(mode_exp_t'{4'd0, 4'b0000});
    rst_n = 1'b1;
    wait_change(40, n);
    chk("post_async_reset_latency", 64'(n), 64'd16);
    repeat (3) step();

    chk("mode_queue_drained", 64'(q_mode.size()), 64'd0);
    chk("rd_queue_drained", 64'(q_rd.size()), 64'd0);
    chk("wr_queue_drained", 64'(q_wr.size()), 64'd0);
    chk("timeout_queue_drained", 64'(q_to.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
